if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the THCO-MIPS 16-bit pipeline. It owns the PC, issues requests to instruction memory with a req/ack handshake, and keeps the IF/ID pipeline register that feeds the decode stage. It takes the decode stage's jump request and jump target, and implements the single architectural delay slot. Each word it delivers carries an `in_delay_slot` tag, so decode can suppress nested jumps.

## Interface
- `RESET_PC`, default 16'h0000: PC value after reset.
- `ADDR_W`, default 16: instruction-address width (word-addressed).
- `INST_W`, default 16: instruction width.

- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low (0 = reset).
- `stall_i`  in  1  Hold request from the hazard/structural unit; freezes IF/ID.
- `jump_i`  in  1  Decode requests a redirect for the instruction currently in IF/ID.
- `jump_target_addr_i`  in  ADDR_W  Redirect target.
- `imem_req_o`  out  1  Fetch request.
- `imem_addr_o`  out  ADDR_W  Fetch address; always equals the PC.
- `imem_ack_i`  in  1  Memory accepts the request and returns data in the same cycle.
- `imem_data_i`  in  INST_W  Fetched instruction, valid when ack is high.
- `instAddr_o`  out  ADDR_W  IF/ID: address of the instruction.
- `inst_o`  out  INST_W  IF/ID: instruction, or NOP (16'h0800) for a bubble.
- `valid_o`  out  1  IF/ID holds a real instruction.
- `in_delay_slot_o`  out  1  IF/ID instruction is a delay slot.

## Operation
- **Accept event A:** `imem_req_o & imem_ack_i`. While `imem_req_o` is high without ack, `imem_addr_o` stays stable.
- **Request rule:** `imem_req_o = rst & !buf_v`, where `buf_v` is the skid-buffer-valid flag.
- **Sequential PC:** on A, `pc <= pc+1`, wrapping modulo 2^ADDR_W. This is overridden by a redirect, below.
- **IF/ID load:** happens when `stall_i=0`. The source is chosen in priority order:
  - the skid buffer, if `buf_v`;
  - otherwise the memory word, if A;
  - otherwise a bubble: `inst_o=NOP`, `valid_o=0`, `in_delay_slot_o=0`, `instAddr_o` unchanged.
- **Stall:** when `stall_i=1`, IF/ID holds. An A in that cycle writes the word, its address and its tag into the skid buffer (`buf_v<=1`).
- **Jump accept J:** `jump_i & valid_o & !stall_i`. When `stall_i=1`, `jump_i` is ignored; decode re-asserts it.
- **Delay slot:** the first word delivered to IF/ID after the jumping instruction.
- **Redirect, case 1 (delay slot loaded on the J edge):** if IF/ID loads a word (from buffer or memory) on the J edge, that word is the delay slot.
  - It gets `in_delay_slot_o=1`.
  - `pc <= jump_target_addr_i` at that edge.
- **Redirect, case 2 (bubble on the J edge):** if the J edge loads a bubble, capture `tgt <= jump_target_addr_i` and set `redir_v=1`.
  - The next A tags its word as delay slot.
  - That A sets `pc <= tgt` and clears `redir_v`.
  - The tag travels with the word through the skid buffer.
- **One delay slot:** with `buf_v=1` no request is outstanding, so at most one word past the jumping instruction exists. Nothing is ever discarded.
- **Reset** (any time, including mid-request or with the buffer full):
  - outputs: `pc=RESET_PC`, `imem_addr_o=RESET_PC`, `imem_req_o=0`, `instAddr_o=0`, `inst_o=NOP`, `valid_o=0`, `in_delay_slot_o=0`;
  - internal state: `buf_v=0`, `redir_v=0`, `tgt=0`.
  - The memory must drop any in-flight request when `rst=0`.

## Timing
- **Fetch-to-decode latency:** 1 edge. With ack in cycle n, the word appears on IF/ID after edge n.
- **Throughput:** with ack held high, `stall_i=0` and no jumps, one instruction per cycle.
- **First request:** asserted in the first cycle with `rst=1`.
- **Stall release with `buf_v=1`:** the buffer drains into IF/ID on the first unstalled edge. `imem_req_o` re-asserts the following cycle, giving one bubble-free hand-off.
- **Redirect latency:** the first target fetch is requested on the cycle after the delay-slot A (or after J, in case 1).

## Configuration
- **`IF_SKID_BUF_EN` defined:** the skid buffer exists, with behaviour as above.
- **`IF_SKID_BUF_EN` not defined:**
  - no buffer; `imem_req_o = rst & !stall_i`;
  - no A can occur while stalled, so IF/ID sources are memory or bubble only;
  - all other rules are unchanged.

## Structure
- **Shared header (`defines.v`):** `NopInst` (16'h0800), `InstAddrBus`, `InstBus`, and the `RstEnable` polarity value.
- **Sub-module `if_skid_buf`:** one entry holding {addr, inst, ds}. Its inputs are `wr` (A under stall) and `rd` (drain when unstalled); its output is `buf_v`. It is instantiated only under `IF_SKID_BUF_EN`.
- **State machine:** the redirect logic is a two-state FSM, SEQ and REDIR (`redir_v`).

## Test plan
- **Straight-line fetch:** reset release, ack always high → IF/ID shows addr 0,1,2,3 on consecutive edges, `valid_o=1`, `in_delay_slot_o=0`.
- **Stall with skid:** `stall_i` high for 3 cycles while ack=1 at addr 5 → IF/ID holds addr 4. Buffer captures 5 and `imem_req_o` drops. After release, 5 loads, then the fetch of 6 resumes.
- **Jump, case 1:** branch at 8 with target 0x20, ack=1 → IF/ID shows 8, then 9 with `in_delay_slot_o=1`, then 0x20 with `in_delay_slot_o=0`.
- **Jump, case 2:** ack latency 3, branch at 8 with target 0x40 and IF/ID bubble on the J edge → 9 is delivered with ds=1, the next request address is 0x40, and no word 10 appears.
- **Reset mid-request:** `rst=0` while req is pending and the buffer is full → all outputs take their reset values asynchronously, and the first request after release is to `RESET_PC`.
- **Build without `IF_SKID_BUF_EN`:** `stall_i=1` forces `imem_req_o=0`, and the straight-line sequence is unchanged when unstalled.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the THCO-MIPS instruction-fetch stage:
// the NOP encoding used for bubbles and the redirect FSM state codes.
package if_fetch_stage_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;

  localparam logic [0:0] ST_SEQ   = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// One-entry skid buffer {addr, inst, ds} that catches a word accepted from
// instruction memory while IF/ID is stalled.
module if_skid_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_inst,
  input  logic              wr_ds,
  output logic              buf_v,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_inst,
  output logic              rd_ds
);

  logic              r_v;
  logic [ADDR_W-1:0] r_addr;
  logic [INST_W-1:0] r_inst;
  logic              r_ds;

  // wr only happens under stall and rd only without, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v    <= 1'b0;
      r_addr <= '0;
      r_inst <= INST_W'(NOP_INST);
      r_ds   <= 1'b0;
    end else if (wr) begin
      r_v    <= 1'b1;
      r_addr <= wr_addr;
      r_inst <= wr_inst;
      r_ds   <= wr_ds;
    end else if (rd) begin
      r_v    <= 1'b0;
    end
  end

  assign buf_v   = r_v;
  assign rd_addr = r_addr;
  assign rd_inst = r_inst;
  assign rd_ds   = r_ds;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch, IF/ID register and single delay slot.
// Optional skid buffer for words accepted under stall is enabled by IF_SKID_BUF_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output logic              in_delay_slot_o
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_inst_addr;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;
  logic              r_ds;

  logic              w_req;
  logic              w_accept;
  logic              w_load;
  logic              w_jump;
  logic              w_buf_v;
  logic              w_mem_ds;
  logic [ADDR_W-1:0] w_src_addr;
  logic [INST_W-1:0] w_src_inst;
  logic              w_src_ds;

  // A word accepted while a redirect is pending is the delay slot.
  assign w_mem_ds = (r_state == ST_REDIR);

`ifdef IF_SKID_BUF_EN
  logic [ADDR_W-1:0] w_buf_addr;
  logic [INST_W-1:0] w_buf_inst;
  logic              w_buf_ds;

  if_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (w_accept & stall_i),
    .rd      (w_buf_v & ~stall_i),
    .wr_addr (r_pc),
    .wr_inst (imem_data_i),
    .wr_ds   (w_mem_ds),
    .buf_v   (w_buf_v),
    .rd_addr (w_buf_addr),
    .rd_inst (w_buf_inst),
    .rd_ds   (w_buf_ds)
  );

  assign w_req      = rst & ~w_buf_v;
  assign w_src_addr = w_buf_v ? w_buf_addr : r_pc;
  assign w_src_inst = w_buf_v ? w_buf_inst : imem_data_i;
  assign w_src_ds   = w_buf_v ? w_buf_ds   : w_mem_ds;
`else
  assign w_req      = rst & ~stall_i;
  assign w_buf_v    = 1'b0;
  assign w_src_addr = r_pc;
  assign w_src_inst = imem_data_i;
  assign w_src_ds   = w_mem_ds;
`endif

  assign w_accept = w_req & imem_ack_i;
  assign w_load   = ~stall_i & (w_buf_v | w_accept);
  assign w_jump   = jump_i & r_valid & ~stall_i;

  assign imem_req_o      = w_req;
  assign imem_addr_o     = r_pc;
  assign instAddr_o      = r_inst_addr;
  assign inst_o          = r_inst;
  assign valid_o         = r_valid;
  assign in_delay_slot_o = r_ds;

  // PC and redirect FSM: a jump whose edge loads no word is deferred to the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_state <= ST_SEQ;
    end else begin
      if (w_jump && w_load) begin
        r_pc <= jump_target_addr_i;
      end else if (w_accept) begin
        r_pc <= (r_state == ST_REDIR) ? r_tgt : r_pc + ADDR_W'(1);
      end

      case (r_state)
        ST_SEQ: begin
          if (w_jump && !w_load) begin
            r_state <= ST_REDIR;
            r_tgt   <= jump_target_addr_i;
          end
        end
        default: begin
          if (w_accept) r_state <= ST_SEQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_addr <= '0;
      r_inst      <= INST_W'(NOP_INST);
      r_valid     <= 1'b0;
      r_ds        <= 1'b0;
    end else if (!stall_i) begin
      if (w_load) begin
        r_inst_addr <= w_src_addr;
        r_inst      <= w_src_inst;
        r_valid     <= 1'b1;
        r_ds        <= w_src_ds | w_jump;
      end else begin
        r_inst      <= INST_W'(NOP_INST);
        r_valid     <= 1'b0;
        r_ds        <= 1'b0;
      end
    end
  end

endmodule
